wb_resp_slave: RTL and testbench
================================

WB_RESP_SLAVE -- requirements
Module: wb_resp_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width of AW and memory port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of W and memory port; the beat stride is DATA_W/8 bytes.
REQ-003 SHALL have ports, one per line, as below (clock and reset first):
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_awvalid  input  1  write-address valid
- s_awready  output  1  write-address ready
- s_awaddr  input  ADDR_W  burst start byte address
- s_awlen  input  8  beats minus one (0 = 1 beat, 3 = 4 beats)
- s_wvalid  input  1  write-data valid
- s_wready  output  1  write-data ready
- s_wdata  input  DATA_W  write data
- s_wstrb  input  DATA_W/8  byte strobes
- s_wlast  input  1  initiator's last-beat marker
- s_bvalid  output  1  write-response valid
- s_bready  input  1  write-response ready
- s_bresp  output  2  2'b00 OKAY, 2'b10 SLVERR
- mem_ready  input  1  memory can take a write this cycle
- mem_we  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory byte address
- mem_wdata  output  DATA_W  memory write data
- mem_wstrb  output  DATA_W/8  memory byte enables

Function
REQ-004 SHALL implement a 3-state FSM: IDLE, DATA, RESP.
REQ-005 In IDLE, SHALL drive s_awready=1, s_wready=0 and s_bvalid=0.
REQ-006 On s_awvalid&&s_awready, SHALL latch s_awaddr into addr_q and s_awlen into len_q, clear beat_q and err_q, and enter DATA on the next cycle.
REQ-007 SHALL drive s_awready=0 in DATA and RESP; AW is accepted only in IDLE.
REQ-008 In DATA, SHALL drive s_wready=mem_ready combinationally.
REQ-009 On a W handshake (s_wvalid&&s_wready), SHALL assert mem_we in the same cycle, with mem_addr=addr_q, mem_wdata=s_wdata and mem_wstrb=s_wstrb.
REQ-010 SHALL hold mem_we=0 in all other cycles; mem_addr, mem_wdata and mem_wstrb are don't-care when mem_we=0.
REQ-011 On each W handshake, SHALL advance addr_q by DATA_W/8, wrapping modulo 2^ADDR_W with no carry out.
REQ-012 On each W handshake, SHALL increment beat_q, an 8-bit counter.
REQ-013 On the W handshake where beat_q==len_q, SHALL enter RESP on the next cycle; the burst length is always len_q+1 beats, regardless of s_wlast.
REQ-014 SHALL count the s_wvalid=1, mem_ready=0 case as no handshake: state, beat_q and addr_q hold.
REQ-015 In RESP, SHALL drive s_bvalid=1 and s_bresp={err_q,1'b0}.
REQ-016 SHALL hold s_bvalid and s_bresp stable until s_bready.
REQ-017 On s_bvalid&&s_bready, SHALL return to IDLE on the next cycle.
REQ-018 Latency: SHALL assert s_bvalid exactly 1 cycle after the final W handshake.
REQ-019 Minimum turnaround: SHALL accept the next AW no earlier than the cycle after the B handshake.
REQ-020 With s_awlen=255, SHALL accept 256 beats; beat_q SHALL NOT wrap before the compare at REQ-013.

Reset
REQ-021 When rst=1 at a clock edge, SHALL force state to IDLE and clear addr_q, len_q, beat_q and err_q.
REQ-022 Output values during and after reset SHALL be: s_awready=1, s_wready=0, s_bvalid=0, s_bresp=2'b00, mem_we=0.
REQ-023 Reset mid-burst SHALL abandon the burst with no B response; the next AW is accepted as a new burst.

Configuration
REQ-024 SHALL support macro WB_RESP_WLAST_CHECK_EN to compile the s_wlast check in or out.
REQ-025 With WB_RESP_WLAST_CHECK_EN defined, SHALL set err_q on any W handshake where s_wlast != (beat_q==len_q).
REQ-026 err_q SHALL be sticky until the next AW handshake, giving s_bresp=2'b10 for that burst; memory writes still occur.
REQ-027 With WB_RESP_WLAST_CHECK_EN undefined, SHALL ignore s_wlast, hold err_q=0 and always respond with s_bresp=2'b00.

Verification
REQ-028 Single beat: AW addr=0x1000, len=0; W data=0xDEADBEEF, strb=0xF, wlast=1; bready=1 -> one mem_we at 0x1000 with 0xDEADBEEF, bvalid next cycle, bresp=00.
REQ-029 Four-beat burst: AW addr=0x2000, len=3; wvalid held high; mem_ready toggling 1,0,1,0... -> mem_we only when mem_ready=1, at 0x2000/0x2004/0x2008/0x200C in order, then bvalid.
REQ-030 Address wrap: AW addr=0xFFFFFFF8, len=3 -> mem_addr sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-031 Response backpressure: bready held 0 for 5 cycles -> bvalid/bresp stable throughout, awready=0; IDLE entered the cycle after bready=1.
REQ-032 WLAST error (macro on): len=3, wlast=1 on beat 1 -> 4 writes still occur, bresp=10; same stimulus with macro off -> bresp=00.
REQ-033 Reset mid-burst: rst=1 after beat 2 of len=3 -> no bvalid, awready=1 after reset; a new AW len=0 completes with bresp=00.

Source files
------------

// File: rtl/wb_resp_slave.sv
// Write-only burst slave: accepts an AW burst descriptor, forwards each
// W beat straight to a simple memory port, and returns a single B response.
// Optional feature macro: WB_RESP_WLAST_CHECK_EN. When defined, a mismatch
// between s_wlast and the internal last-beat position turns the burst
// response into SLVERR. The writes themselves still go to memory.
module wb_resp_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_q;
  logic                err_q;

  logic                aw_hs;
  logic                w_hs;
  logic                last_beat;

  // A W beat is taken only while in DATA and the memory can absorb it, so
  // s_wready is simply mem_ready there and the write is purely combinational.
  assign aw_hs     = (state_q == IDLE) && s_awvalid;
  assign w_hs      = (state_q == DATA) && s_wvalid && mem_ready;
  assign last_beat = (beat_q == len_q);

  assign mem_we    = w_hs;
  assign mem_addr  = addr_q;
  assign mem_wdata = s_wdata;
  assign mem_wstrb = s_wstrb;

`ifndef WB_RESP_WLAST_CHECK_EN
  // s_wlast has no function when the check is compiled out.
  logic unused_wlast;
  assign unused_wlast = s_wlast;
`endif

  // Next-state and handshake outputs for the IDLE -> DATA -> RESP sequence.
  always_comb begin
    state_d   = state_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    case (state_q)
      IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) state_d = DATA;
      end
      DATA: begin
        s_wready = mem_ready;
        // Burst length comes from AW alone; s_wlast never ends a burst.
        if (w_hs && last_beat) state_d = RESP;
      end
      RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = {err_q, 1'b0};
        if (s_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus burst bookkeeping (address, beat count, error flag).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        addr_q <= s_awaddr;
        len_q  <= s_awlen;
        beat_q <= '0;
        err_q  <= 1'b0;
      end
      if (w_hs) begin
        // Address wraps modulo 2^ADDR_W. beat_q may roll over after the
        // 256th beat, but the last-beat compare has already fired by then.
        addr_q <= addr_q + STRIDE;
        beat_q <= beat_q + 8'd1;
`ifdef WB_RESP_WLAST_CHECK_EN
        if (s_wlast != last_beat) err_q <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_wb_resp_slave.sv
// Testbench for wb_resp_slave: scoreboarded memory writes and B responses.
module tb_wb_resp_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] respq[$];

`ifdef WB_RESP_WLAST_CHECK_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  wb_resp_slave #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL mem_unexpected: got write addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d || mem_wstrb !== e.s) begin
          miscompares++;
          $display("FAIL mem_write: got addr=%h data=%h strb=%h, required addr=%h data=%h strb=%h",
                   mem_addr, mem_wdata, mem_wstrb, e.a, e.d, e.s);
        end
      end
    end
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] strb_of(input int beat);
    return (beat % 2 == 1) ? 4'h3 : 4'hF;
  endfunction

  // Full burst: AW, W beats (optionally with mem_ready toggling), B with
  // optional backpressure. bad_beat >= 0 puts wlast on that beat instead of
  // the true last one.
  task automatic do_burst(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] dbase, input int bad_beat,
                          input bit toggle, input int bdelay,
                          input logic [1:0] exp_resp);
    int         beat;
    int         cyc;
    bit         hs;
    logic [1:0] b0;
    wr_t        e;
    s_awvalid = 1'b1;
    s_awaddr  = addr;
    s_awlen   = len;
    @(negedge clk);
    vectors++;
    if (s_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL aw_ready: got %b, required 1", s_awready);
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      e.a = addr + 32'(4 * i);
      e.d = dbase + 32'(i);
      e.s = strb_of(i);
      wq.push_back(e);
    end
    respq.push_back(exp_resp);
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 2000) begin
      s_wvalid  = 1'b1;
      s_wdata   = dbase + 32'(beat);
      s_wstrb   = strb_of(beat);
      s_wlast   = (bad_beat >= 0) ? (beat == bad_beat) : (beat == int'(len));
      mem_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      vectors++;
      if (s_wready !== mem_ready || s_awready !== 1'b0) begin
        miscompares++;
        $display("FAIL w_ready: got wready=%b awready=%b, required wready=%b awready=0",
                 s_wready, s_awready, mem_ready);
      end
      hs = mem_ready;
      @(posedge clk); #1;
      if (hs) beat++;
      cyc++;
    end
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    mem_ready = 1'b1;
    if (cyc >= 2000) begin
      miscompares++;
      $display("FAIL w_timeout: got %0d beats, required %0d", beat, int'(len) + 1);
    end
    @(negedge clk);
    vectors++;
    if (s_bvalid !== 1'b1 || s_awready !== 1'b0) begin
      miscompares++;
      $display("FAIL b_latency: got bvalid=%b awready=%b, required bvalid=1 awready=0", s_bvalid, s_awready);
    end
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL mem_count: got %0d writes missing, required 0", wq.size());
      wq.delete();
    end
    vectors++;
    b0 = respq.pop_front();
    if (s_bresp !== b0) begin
      miscompares++;
      $display("FAIL b_resp: got %b, required %b", s_bresp, b0);
    end
    repeat (bdelay) begin
      @(negedge clk);
      vectors++;
      if (s_bvalid !== 1'b1 || s_bresp !== b0 || s_awready !== 1'b0) begin
        miscompares++;
        $display("FAIL b_hold: got bvalid=%b bresp=%b awready=%b, required 1/%b/0",
                 s_bvalid, s_bresp, s_awready, b0);
      end
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1) begin
      miscompares++;
      $display("FAIL b_to_idle: got bvalid=%b awready=%b, required 0/1", s_bvalid, s_awready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_awlen   = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (s_awready !== 1'b1 || s_wready !== 1'b0 || s_bvalid !== 1'b0 ||
        s_bresp !== 2'b00 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b resp=%b we=%b, required 1/0/0/00/0",
               s_awready, s_wready, s_bvalid, s_bresp, mem_we);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_awready !== 1'b1 || s_wready !== 1'b0 || s_bvalid !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: got aw=%b w=%b b=%b we=%b, required 1/0/0/0",
               s_awready, s_wready, s_bvalid, mem_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_burst(32'h0000_1000, 8'd0, 32'hDEAD_BEEF, -1, 1'b0, 0, 2'b00);
  endtask

  task automatic test_toggle_ready();
    do_burst(32'h0000_2000, 8'd3, 32'h1111_0000, -1, 1'b1, 0, 2'b00);
  endtask

  task automatic test_wrap();
    do_burst(32'hFFFF_FFF8, 8'd3, 32'h2222_0000, -1, 1'b0, 0, 2'b00);
  endtask

  task automatic test_backpressure();
    do_burst(32'h0000_4000, 8'd1, 32'h3333_0000, -1, 1'b0, 5, 2'b00);
  endtask

  task automatic test_wlast_error();
    do_burst(32'h0000_5000, 8'd3, 32'h4444_0000, 1, 1'b0, 0, ERR_RESP);
    // Error flag must not carry into the next burst.
    do_burst(32'h0000_5100, 8'd1, 32'h4545_0000, -1, 1'b0, 0, 2'b00);
  endtask

  task automatic test_mid_reset();
    wr_t e;
    s_awvalid = 1'b1;
    s_awaddr  = 32'h0000_3000;
    s_awlen   = 8'd3;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.a = 32'h0000_3000 + 32'(4 * i);
      e.d = 32'h5555_0000 + 32'(i);
      e.s = strb_of(i);
      wq.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      s_wvalid = 1'b1;
      s_wdata  = 32'h5555_0000 + 32'(i);
      s_wstrb  = strb_of(i);
      s_wlast  = 1'b0;
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_writes: got %0d writes missing, required 0", wq.size());
      wq.delete();
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_idle: got bvalid=%b awready=%b wready=%b, required 0/1/0",
                 s_bvalid, s_awready, s_wready);
      end
    end
    @(posedge clk); #1;
    do_burst(32'h0000_3100, 8'd0, 32'h5656_0000, -1, 1'b0, 0, 2'b00);
  endtask

  task automatic test_max_len();
    do_burst(32'h0001_0000, 8'd255, 32'h7700_0000, -1, 1'b0, 0, 2'b00);
  endtask

  task automatic test_back_to_back();
    do_burst(32'h0000_6000, 8'd2, 32'h6666_0000, -1, 1'b1, 0, 2'b00);
    do_burst(32'h0000_7000, 8'd0, 32'h6767_0000, -1, 1'b0, 1, 2'b00);
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle_ready();
    test_wrap();
    test_backpressure();
    test_wlast_error();
    test_mid_reset();
    test_max_len();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
